// File: rtl/signed_serial_subtractor.sv
// Bit-serial two's-complement subtractor, DIFF = A - B, LSB first.
// Ports: clk, rst_n (async low), in_valid/in_ready + A/B operands,
//        out_valid/out_ready + DIFF/OVF result. One full-adder cell,
//        WIDTH cycles per operation, optional saturation on overflow.
module signed_serial_subtractor #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] DIFF,
   output logic             OVF
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] nb_sh;
   logic [WIDTH-2:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_nx;
   logic             last;
   logic             ovf_nx;
   logic [WIDTH-1:0] full;
   logic [WIDTH-1:0] sat_val;

   // Single full-adder cell: A + ~B + 1 with carry seeded to 1.
   assign sum_bit  = a_sh[0] ^ nb_sh[0] ^ carry;
   assign carry_nx = (a_sh[0] & nb_sh[0]) | (carry & (a_sh[0] ^ nb_sh[0]));
   assign last     = (cnt == CW'(WIDTH - 1));
   assign full     = {sum_bit, res};

   // On the MSB step, carry holds the carry into the MSB.
   assign ovf_nx   = carry ^ carry_nx;

   // a_sh[0] is A's sign bit on the MSB step.
   assign sat_val  = a_sh[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = CALC;
         CALC: if (last) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         nb_sh <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         DIFF  <= '0;
         OVF   <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_sh  <= A;
            nb_sh <= ~B;
            carry <= 1'b1;
            cnt   <= '0;
         end
      end else if (state == CALC) begin
         a_sh  <= a_sh >> 1;
         nb_sh <= nb_sh >> 1;
         res   <= full[WIDTH-1:1];
         carry <= carry_nx;
         cnt   <= cnt + CW'(1);
         if (last) begin
            OVF  <= ovf_nx;
            DIFF <= (SATURATE && ovf_nx) ? sat_val : full;
         end
      end
   end

endmodule
